// File: rtl/cdb_arbiter_pkg.sv
// Shared configuration for the common data bus: ROB tag/data types, idle tag,
// FIFO depth default and the round-robin source encoding.
package cdb_arbiter_pkg;

  localparam int ROB_ID_WIDTH   = 4;
  localparam int CDB_DATA_WIDTH = 32;
  localparam int CDB_FIFO_DEPTH = 4;

  typedef logic [ROB_ID_WIDTH-1:0]   rob_tag_t;
  typedef logic [CDB_DATA_WIDTH-1:0] cdb_data_t;

  localparam rob_tag_t CDB_IDLE_TAG = 4'd0;

  typedef enum logic {
    RR_RS  = 1'b0,
    RR_LSB = 1'b1
  } rr_src_e;

  function automatic rr_src_e rr_other(input rr_src_e src);
    rr_src_e result;
    case (src)
      RR_RS:   result = RR_LSB;
      RR_LSB:  result = RR_RS;
      default: result = RR_RS;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-producer result FIFO: {tag,value,next_pc} payload, pre-full flag, and an
// empty-bypass head so an uncontended result reaches the CDB one cycle later.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int ID_WIDTH   = ROB_ID_WIDTH,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int DEPTH      = CDB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [ID_WIDTH-1:0]   in_tag,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic [DATA_WIDTH-1:0] in_next_pc,
  input  logic                  deq,
  output logic                  head_valid,
  output logic [ID_WIDTH-1:0]   head_tag,
  output logic [DATA_WIDTH-1:0] head_value,
  output logic [DATA_WIDTH-1:0] head_next_pc,
  output logic                  full
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PAYLOAD_W = ID_WIDTH + 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH - 1);

  logic [PAYLOAD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;

  logic                 empty_s;
  logic                 push_s;
  logic                 store_s;
  logic                 pop_s;
  logic [PAYLOAD_W-1:0] in_payload_s;
  logic [PAYLOAD_W-1:0] head_payload_s;

  // Head selection: an empty FIFO exposes the incoming result directly.
  always_comb begin
    empty_s        = (count_r == {CNT_W{1'b0}});
    push_s         = rdy && (in_tag != ID_WIDTH'(CDB_IDLE_TAG));
    in_payload_s   = {in_tag, in_value, in_next_pc};
    head_payload_s = {PAYLOAD_W{1'b0}};
    head_valid     = 1'b0;
    if (empty_s) begin
      head_payload_s = in_payload_s;
      head_valid     = push_s;
    end else begin
      head_payload_s = mem_r[rd_ptr_r];
      head_valid     = 1'b1;
    end
    {head_tag, head_value, head_next_pc} = head_payload_s;
    full = (count_r >= FULL_CNT);
  end

  // Storage decisions; kept apart from the head logic because deq depends on head_valid.
  always_comb begin
    pop_s   = rdy && deq && !empty_s;
    // A bypassed result that wins arbitration is consumed without being stored.
    store_s = push_s && !(empty_s && deq) && (count_r != DEPTH_CNT);
  end

  // Payload storage (no reset needed; validity is tracked by count_r).
  always_ff @(posedge clk) begin
    if (!rst && store_s) begin
      mem_r[wr_ptr_r] <= in_payload_s;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + {{(CNT_W-1){1'b0}}, store_s} - {{(CNT_W-1){1'b0}}, pop_s};
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: RS and LSB result FIFOs feed a round-robin grant
// that loads one result per cycle into the registered CDB outputs.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ID_WIDTH   = ROB_ID_WIDTH,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int DEPTH      = CDB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  reset_from_rob_bus,
  input  logic [ID_WIDTH-1:0]   dest_from_rs,
  input  logic [DATA_WIDTH-1:0] value_from_rs,
  input  logic [DATA_WIDTH-1:0] next_pc_from_rs,
  input  logic [ID_WIDTH-1:0]   dest_from_lsb,
  input  logic [DATA_WIDTH-1:0] value_from_lsb,
  output logic [ID_WIDTH-1:0]   dest_to_cdb,
  output logic [DATA_WIDTH-1:0] value_to_cdb,
  output logic [DATA_WIDTH-1:0] next_pc_to_cdb,
  output logic                  is_rs_fifo_full,
  output logic                  is_lsb_fifo_full
);

  logic                  flush_s;
  rr_src_e               rr_r;
  rr_src_e               rr_next_s;

  logic                  rs_valid_s;
  logic [ID_WIDTH-1:0]   rs_tag_s;
  logic [DATA_WIDTH-1:0] rs_value_s;
  logic [DATA_WIDTH-1:0] rs_next_pc_s;
  logic                  lsb_valid_s;
  logic [ID_WIDTH-1:0]   lsb_tag_s;
  logic [DATA_WIDTH-1:0] lsb_value_s;
  logic [DATA_WIDTH-1:0] lsb_next_pc_s;

  logic                  grant_rs_s;
  logic                  grant_lsb_s;
  logic [ID_WIDTH-1:0]   dest_next_s;
  logic [DATA_WIDTH-1:0] value_next_s;
  logic [DATA_WIDTH-1:0] next_pc_next_s;

  assign flush_s = rst || reset_from_rob_bus;

  cdb_fifo #(
    .ID_WIDTH  (ID_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_rs_fifo (
    .clk         (clk),
    .rst         (flush_s),
    .rdy         (rdy),
    .in_tag      (dest_from_rs),
    .in_value    (value_from_rs),
    .in_next_pc  (next_pc_from_rs),
    .deq         (grant_rs_s),
    .head_valid  (rs_valid_s),
    .head_tag    (rs_tag_s),
    .head_value  (rs_value_s),
    .head_next_pc(rs_next_pc_s),
    .full        (is_rs_fifo_full)
  );

  // Loads and stores never redirect control flow, so their next pc is carried as zero.
  cdb_fifo #(
    .ID_WIDTH  (ID_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_lsb_fifo (
    .clk         (clk),
    .rst         (flush_s),
    .rdy         (rdy),
    .in_tag      (dest_from_lsb),
    .in_value    (value_from_lsb),
    .in_next_pc  ({DATA_WIDTH{1'b0}}),
    .deq         (grant_lsb_s),
    .head_valid  (lsb_valid_s),
    .head_tag    (lsb_tag_s),
    .head_value  (lsb_value_s),
    .head_next_pc(lsb_next_pc_s),
    .full        (is_lsb_fifo_full)
  );

  // Grant selection and CDB next-state; the pointer only moves on a contended grant.
  always_comb begin
    grant_rs_s     = 1'b0;
    grant_lsb_s    = 1'b0;
    rr_next_s      = rr_r;
    dest_next_s    = {ID_WIDTH{1'b0}};
    value_next_s   = {DATA_WIDTH{1'b0}};
    next_pc_next_s = {DATA_WIDTH{1'b0}};
    if (rdy && rs_valid_s && lsb_valid_s) begin
      case (rr_r)
        RR_RS:   grant_rs_s  = 1'b1;
        RR_LSB:  grant_lsb_s = 1'b1;
        default: grant_rs_s  = 1'b1;
      endcase
      rr_next_s = rr_other(rr_r);
    end else if (rdy && rs_valid_s) begin
      grant_rs_s = 1'b1;
    end else if (rdy && lsb_valid_s) begin
      grant_lsb_s = 1'b1;
    end else begin
      grant_rs_s  = 1'b0;
      grant_lsb_s = 1'b0;
    end

    if (grant_rs_s) begin
      dest_next_s    = rs_tag_s;
      value_next_s   = rs_value_s;
      next_pc_next_s = rs_next_pc_s;
    end else if (grant_lsb_s) begin
      dest_next_s    = lsb_tag_s;
      value_next_s   = lsb_value_s;
      next_pc_next_s = lsb_next_pc_s;
    end else begin
      dest_next_s    = {ID_WIDTH{1'b0}};
      value_next_s   = {DATA_WIDTH{1'b0}};
      next_pc_next_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Registered CDB and round-robin pointer; a frozen cycle broadcasts idle.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      rr_r           <= RR_RS;
      dest_to_cdb    <= {ID_WIDTH{1'b0}};
      value_to_cdb   <= {DATA_WIDTH{1'b0}};
      next_pc_to_cdb <= {DATA_WIDTH{1'b0}};
    end else begin
      rr_r           <= rr_next_s;
      dest_to_cdb    <= dest_next_s;
      value_to_cdb   <= value_next_s;
      next_pc_to_cdb <= next_pc_next_s;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected CDB
// broadcasts into a queue, a negedge monitor pops and compares them.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        reset_from_rob_bus;
  logic [3:0]  dest_from_rs;
  logic [31:0] value_from_rs;
  logic [31:0] next_pc_from_rs;
  logic [3:0]  dest_from_lsb;
  logic [31:0] value_from_lsb;
  logic [3:0]  dest_to_cdb;
  logic [31:0] value_to_cdb;
  logic [31:0] next_pc_to_cdb;
  logic        is_rs_fifo_full;
  logic        is_lsb_fifo_full;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] value;
    logic [31:0] next_pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   any_order = 1'b0;

  cdb_arbiter #(
    .ID_WIDTH  (4),
    .DATA_WIDTH(32),
    .DEPTH     (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .reset_from_rob_bus(reset_from_rob_bus),
    .dest_from_rs      (dest_from_rs),
    .value_from_rs     (value_from_rs),
    .next_pc_from_rs   (next_pc_from_rs),
    .dest_from_lsb     (dest_from_lsb),
    .value_from_lsb    (value_from_lsb),
    .dest_to_cdb       (dest_to_cdb),
    .value_to_cdb      (value_to_cdb),
    .next_pc_to_cdb    (next_pc_to_cdb),
    .is_rs_fifo_full   (is_rs_fifo_full),
    .is_lsb_fifo_full  (is_lsb_fifo_full)
  );

  always #5 clk = ~clk;

  // Payload encodings: top nibble of the value identifies the producer.
  function automatic logic [31:0] rs_val(input logic [3:0] t);
    return 32'hA000_0000 | ({28'h0, t} * 32'h0000_0101);
  endfunction

  function automatic logic [31:0] rs_pc(input logic [3:0] t);
    return 32'h0000_4000 + ({28'h0, t} * 32'd4);
  endfunction

  function automatic logic [31:0] lsb_val(input logic [3:0] t);
    return 32'hB000_0000 | ({28'h0, t} * 32'h0001_0001);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic exp_push(input bit from_lsb, input logic [3:0] t);
    exp_t e;
    e.tag     = t;
    e.value   = from_lsb ? lsb_val(t) : rs_val(t);
    e.next_pc = from_lsb ? 32'h0 : rs_pc(t);
    exp_q.push_back(e);
  endtask

  task automatic set_inputs(input logic [3:0] rt, input logic [3:0] lt);
    dest_from_rs    = rt;
    value_from_rs   = rs_val(rt);
    next_pc_from_rs = rs_pc(rt);
    dest_from_lsb   = lt;
    value_from_lsb  = lsb_val(lt);
  endtask

  task automatic drive(input logic [3:0] rt, input logic [3:0] lt);
    @(negedge clk);
    set_inputs(rt, lt);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'd0, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_inputs(4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every nonzero broadcast must match the oldest expected entry
  // (or, in any_order mode, the oldest entry from the same producer).
  always @(negedge clk) begin
    if (dest_to_cdb != 4'd0) begin
      int idx;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (idx < 0 && (!any_order || exp_q[i].value[31:28] == value_to_cdb[31:28])) idx = i;
      end
      if (idx < 0) begin
        checks++;
        $display("FAIL unexpected_broadcast: got tag %0d value %h expected no broadcast",
                 dest_to_cdb, value_to_cdb);
      end else begin
        chk("cdb_tag", {28'h0, dest_to_cdb}, {28'h0, exp_q[idx].tag});
        chk("cdb_value", value_to_cdb, exp_q[idx].value);
        chk("cdb_next_pc", next_pc_to_cdb, exp_q[idx].next_pc);
        exp_q.delete(idx);
      end
    end
  end

  initial begin
    int lsb_tag_seq;
    int lsb_blocked;
    logic [3:0] rt;
    logic [3:0] lt;

    rst = 1'b1;
    rdy = 1'b1;
    reset_from_rob_bus = 1'b0;
    set_inputs(4'd0, 4'd0);
    repeat (2) @(negedge clk);
    chk("reset_dest", {28'h0, dest_to_cdb}, 32'd0);
    chk("reset_value", value_to_cdb, 32'd0);
    chk("reset_next_pc", next_pc_to_cdb, 32'd0);
    chk("reset_rs_full", {31'h0, is_rs_fifo_full}, 32'd0);
    chk("reset_lsb_full", {31'h0, is_lsb_fifo_full}, 32'd0);
    rst = 1'b0;

    // 1: single RS result, one-cycle latency then idle
    drive(4'd3, 4'd0); exp_push(1'b0, 4'd3);
    drive(4'd0, 4'd0);
    @(negedge clk);
    chk("single_then_idle", {28'h0, dest_to_cdb}, 32'd0);
    chk("single_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: contention after reset -> RS first; pointer then favours LSB
    do_reset();
    drive(4'd2, 4'd5); exp_push(1'b0, 4'd2); exp_push(1'b1, 4'd5);
    idle(3);
    drive(4'd9, 4'd10); exp_push(1'b1, 4'd10); exp_push(1'b0, 4'd9);
    idle(4);
    chk("contention_drained", 32'(exp_q.size()), 32'd0);

    // 3a: sustained both, short burst -> 1,4,2,5,3,6
    do_reset();
    drive(4'd1, 4'd4); exp_push(1'b0, 4'd1); exp_push(1'b1, 4'd4);
    drive(4'd2, 4'd5); exp_push(1'b0, 4'd2); exp_push(1'b1, 4'd5);
    drive(4'd3, 4'd6); exp_push(1'b0, 4'd3); exp_push(1'b1, 4'd6);
    idle(8);
    chk("burst_drained", 32'(exp_q.size()), 32'd0);

    // 3b: longer burst until both FIFOs hold 3 entries
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'(i + 1), 4'(i + 9));
      exp_push(1'b0, 4'(i + 1));
      exp_push(1'b1, 4'(i + 9));
      if (i == 4) begin
        chk("full_rs_at2", {31'h0, is_rs_fifo_full}, 32'd0);
        chk("full_lsb_at2", {31'h0, is_lsb_fifo_full}, 32'd0);
      end else if (i == 5) begin
        chk("full_rs_at2b", {31'h0, is_rs_fifo_full}, 32'd0);
        chk("full_lsb_at3", {31'h0, is_lsb_fifo_full}, 32'd1);
      end
    end
    drive(4'd0, 4'd0);
    chk("full_rs_at3", {31'h0, is_rs_fifo_full}, 32'd1);
    chk("full_lsb_at3b", {31'h0, is_lsb_fifo_full}, 32'd1);
    idle(10);
    chk("full_rs_drained", {31'h0, is_rs_fifo_full}, 32'd0);
    chk("full_lsb_drained", {31'h0, is_lsb_fifo_full}, 32'd0);
    chk("long_burst_drained", 32'(exp_q.size()), 32'd0);

    // 4: flush with entries queued; queued tags must never appear
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'(i + 1), 4'(i + 9));
      if (i < 3) begin
        exp_push(1'b0, 4'(i + 1));
        exp_push(1'b1, 4'(i + 9));
      end
    end
    @(negedge clk);
    chk("preflush_rs_full", {31'h0, is_rs_fifo_full}, 32'd1);
    set_inputs(4'd7, 4'd15);
    reset_from_rob_bus = 1'b1;
    @(negedge clk);
    reset_from_rob_bus = 1'b0;
    set_inputs(4'd0, 4'd0);
    chk("flush_dest", {28'h0, dest_to_cdb}, 32'd0);
    chk("flush_rs_full", {31'h0, is_rs_fifo_full}, 32'd0);
    chk("flush_lsb_full", {31'h0, is_lsb_fifo_full}, 32'd0);
    idle(8);
    chk("flush_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: freeze with an entry pending; inputs during freeze are ignored
    do_reset();
    drive(4'd7, 4'd8); exp_push(1'b0, 4'd7); exp_push(1'b1, 4'd8);
    @(negedge clk);
    rdy = 1'b0;
    set_inputs(4'd15, 4'd14);
    @(negedge clk);
    chk("freeze_dest_1", {28'h0, dest_to_cdb}, 32'd0);
    @(negedge clk);
    chk("freeze_dest_2", {28'h0, dest_to_cdb}, 32'd0);
    rdy = 1'b1;
    set_inputs(4'd0, 4'd0);
    idle(4);
    chk("freeze_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: RS every other cycle, LSB saturating under its full flag; per-producer order
    do_reset();
    any_order = 1'b1;
    lsb_tag_seq = 0;
    lsb_blocked = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rt = (c % 2 == 0) ? 4'(c / 2 + 1) : 4'd0;
      if (is_lsb_fifo_full) begin
        lt = 4'd0;
        lsb_blocked++;
      end else begin
        lt = 4'(lsb_tag_seq % 5 + 11);
        lsb_tag_seq++;
      end
      set_inputs(rt, lt);
      if (rt != 4'd0) exp_push(1'b0, rt);
      if (lt != 4'd0) exp_push(1'b1, lt);
    end
    idle(24);
    chk("lsb_throttled", {31'h0, lsb_blocked > 0}, 32'd1);
    chk("order_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", {28'h0, dest_to_cdb}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
